// File: rtl/led_seq_pkg.sv
// Shared types and default timing constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    localparam int DEFAULT_TICK_DIV        = 6000000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;

    localparam logic [3:0] LEDS_FIRST = 4'b0001;
    localparam logic [3:0] LEDS_ALL   = 4'b1111;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer, registered press pulse.
// The press pulse fires on the cycle the debounced level rises; release produces nothing.
module btn_debounce
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample that matches the accepted level restarts the qualification run.
            if (sync2 != level) begin
                if (count == COUNT_LAST) begin
                    level <= sync2;
                    count <= '0;
                    press <= sync2;
                end else begin
                    count <= count + CW'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Four-mode LED pattern sequencer stepped by a tick divider, mode advanced by a debounced button.
// A press on the same cycle as a tick wins: the pattern reloads and the divider restarts.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
    output logic [3:0] leds,
    output logic       led_status,
    output logic [1:0] mode
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic          press;
    mode_t         state;
    mode_t         state_d;
    logic [DW-1:0] div;
    logic          dir_up;
    logic          tick;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_ROTATE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        tick    = (state != MODE_HOLD) && (div == DIV_LAST);
        if (press) begin
            state_d = next_mode(state);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            leds       <= LEDS_FIRST;
            led_status <= 1'b0;
            dir_up     <= 1'b1;
        end else if (press) begin
            div <= '0;
            case (state_d)
                MODE_ROTATE, MODE_BOUNCE: begin
                    leds   <= LEDS_FIRST;
                    dir_up <= 1'b1;
                end
                MODE_BLINK: leds       <= LEDS_ALL;
                MODE_HOLD:  led_status <= 1'b1;
                default: ;
            endcase
        end else if (state != MODE_HOLD) begin
            if (tick) begin
                div        <= '0;
                led_status <= ~led_status;
                case (state)
                    MODE_ROTATE: leds <= {leds[2:0], leds[3]};
                    MODE_BOUNCE: begin
                        // Reverse at the ends so an end value is never shown twice in a row.
                        if (dir_up) begin
                            if (leds[3]) begin
                                leds   <= 4'b0100;
                                dir_up <= 1'b0;
                            end else begin
                                leds <= leds << 1;
                            end
                        end else begin
                            if (leds[0]) begin
                                leds   <= 4'b0010;
                                dir_up <= 1'b1;
                            end else begin
                                leds <= leds >> 1;
                            end
                        end
                    end
                    MODE_BLINK: leds <= ~leds;
                    default: ;
                endcase
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    assign mode = state;

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 6000000, clk cycles per pattern step (0.5 s at 12 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000, consecutive stable samples required to accept a new sw level (10 ms at 12 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw  input  1  raw push-button, active-high, asynchronous to clk, may bounce.
REQ-006 SHALL have port leds  output  4  pattern for D1..D4, bit 0 = D1.
REQ-007 SHALL have port led_status  output  1  status LED D5.
REQ-008 SHALL have port mode  output  2  current mode encoding.

Function
REQ-009 SHALL pass sw through a 2-flop synchronizer before any other use.
REQ-010 SHALL update the debounced level only after the synchronized sw differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate match restarts the count.
REQ-011 SHALL generate a registered one-cycle press pulse on each debounced 0->1 transition; a held button yields exactly one pulse; release yields none.
REQ-012 SHALL run a divider 0..TICK_DIV-1, producing a one-cycle tick when divider = TICK_DIV-1, then wrap to 0.
REQ-013 SHALL implement mode FSM ROTATE(0) -> BOUNCE(1) -> BLINK(2) -> HOLD(3) -> ROTATE, advancing one state on the cycle after a press pulse; no other transitions.
REQ-014 SHALL on each mode change clear the divider, so the first step in the new mode occurs TICK_DIV cycles after the change.
REQ-015 SHALL on entering ROTATE or BOUNCE load leds = 0001 and direction = up; on entering BLINK load leds = 1111; on entering HOLD leave leds unchanged.
REQ-016 SHALL in ROTATE rotate leds left one position per tick: 0001, 0010, 0100, 1000, 0001.
REQ-017 SHALL in BOUNCE move the single lit bit one position per tick, reversing at the ends: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; never repeat an end value.
REQ-018 SHALL in BLINK toggle leds between 1111 and 0000 per tick.
REQ-019 SHALL in HOLD freeze leds and halt the divider.
REQ-020 SHALL drive led_status as a heartbeat toggling on every tick in ROTATE, BOUNCE, BLINK, and constant 1 in HOLD.
REQ-021 SHALL, when press pulse and tick coincide, give the press priority: the tick is discarded and REQ-015 applies.
REQ-022 SHALL register all outputs; no combinational path from sw to any output.

Reset
REQ-023 SHALL on rst_n low immediately set: mode = ROTATE, leds = 0001, led_status = 0, direction = up, divider = 0, synchronizer/debounced level/debounce count/press = 0.
REQ-024 SHALL treat a button held through reset release as a new press, accepted DEBOUNCE_CYCLES after synchronization.
REQ-025 SHALL resume normal operation on the first clk edge after rst_n rises; a reset mid-pattern abandons the pattern without completing it.

Structure
REQ-026 SHALL place mode_t (MODE_ROTATE=0, MODE_BOUNCE=1, MODE_BLINK=2, MODE_HOLD=3) and the default TICK_DIV/DEBOUNCE_CYCLES constants in package led_seq_pkg.
REQ-027 SHALL implement synchronizer, debounce and press pulse (REQ-009..011) in one sub-module btn_debounce, parameterized by DEBOUNCE_CYCLES, same clk/rst_n.
REQ-028 SHALL size divider and debounce counters with $clog2 of their parameters.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-029 SHALL test: reset release, sw=0 -> mode 0, leds 0001, 0010, 0100, 1000, 0001 at 4-cycle spacing; led_status toggles each step.
REQ-030 SHALL test: sw pulses high for 2 cycles, three times, with low gaps -> no press, mode stays 0.
REQ-031 SHALL test: clean press held 20 cycles -> exactly one advance to mode 1; leds 0001, then 0010, 0100, 1000, 0100, 0010, 0001.
REQ-032 SHALL test: press pulse aligned with tick in ROTATE at leds 0100 -> mode 1, leds 0001, next step after 4 cycles gives 0010.
REQ-033 SHALL test: three presses reaching HOLD at leds 0000 or 1111 -> leds frozen 50 cycles, led_status = 1; fourth press -> mode 0, leds 0001.
REQ-034 SHALL test: rst_n low mid-BLINK, between clk edges -> leds 0001, mode 0, led_status 0 before the next edge.
